// File: rtl/rf_pkg.sv
// Shared definitions for the integer register file: default sizes, sweep/run state,
// and the hardwired-zero register address.
package rf_pkg;

    localparam int unsigned XLEN_DEF  = 32;
    localparam int unsigned NREGS_DEF = 32;
    localparam int unsigned AW_DEF    = 5;

    localparam int unsigned ZERO_ADDR = 0;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } rf_state_e;

endpackage

// File: rtl/reg_file_clr_word_reg.sv
// One architectural register word: holds its value unless the load select is high.
module word_reg
    import rf_pkg::*;
#(
    parameter int unsigned W = XLEN_DEF
) (
    input  logic         clk,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] word_q;
    logic [W-1:0] word_d;

    always_comb begin
        word_d = word_q;
        if (load) begin
            word_d = d;
        end
    end

    always_ff @(posedge clk) begin
        word_q <= word_d;
    end

    assign q = word_q;

endmodule

// File: rtl/reg_file_clr.sv
// Integer register file, 2 async read ports / 1 sync write port. After reset a sweep
// zeroes one register per cycle so no global clear is needed on the storage.
module reg_file_clr
    import rf_pkg::*;
#(
    parameter int unsigned XLEN   = XLEN_DEF,
    parameter int unsigned NREGS  = NREGS_DEF,
    parameter int unsigned AW     = AW_DEF,
    parameter int unsigned BYPASS = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [AW-1:0]   rd_addr,
    input  logic [XLEN-1:0] rd_data,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            busy
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(NREGS - 1);
    localparam logic [AW-1:0] ZERO      = AW'(ZERO_ADDR);
    localparam bit            BYP_EN    = (BYPASS != 0);

    rf_state_e     state_q;
    rf_state_e     state_d;
    logic [AW-1:0] cnt_q;
    logic [AW-1:0] cnt_d;

    logic            in_run;
    logic [XLEN-1:0] wr_data;
    logic [XLEN-1:0] regs [NREGS];

    // Sweep sequencer; cnt holds at the last address instead of wrapping.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == CLEAR) begin
            if (cnt_q == LAST_ADDR) begin
                state_d = RUN;
            end else begin
                cnt_d = cnt_q + AW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR;
            cnt_q   <= AW'(1);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_run  = (state_q == RUN);
    assign busy    = (state_q == CLEAR);
    assign wr_data = in_run ? rd_data : '0;

    assign regs[0] = '0;

    // rst masks every load so the reset edge never disturbs storage.
    for (genvar i = 1; i < NREGS; i++) begin : g_word
        logic load;
        assign load = !rst &&
                      (( in_run && we && (rd_addr == AW'(i))) ||
                       (!in_run && (cnt_q == AW'(i))));
        word_reg #(.W(XLEN)) u_word (
            .clk  (clk),
            .load (load),
            .d    (wr_data),
            .q    (regs[i])
        );
    end

    function automatic logic [XLEN-1:0] read_port(
        input logic            run,
        input logic [AW-1:0]   addr,
        input logic            wen,
        input logic [AW-1:0]   waddr,
        input logic [XLEN-1:0] wdata,
        input logic [XLEN-1:0] stored
    );
        logic [XLEN-1:0] val;
        val = '0;
        if (run && (addr != ZERO)) begin
            if (BYP_EN && wen && (waddr == addr)) begin
                val = wdata;
            end else begin
                val = stored;
            end
        end
        return val;
    endfunction

    always_comb begin
        rs1_data = read_port(in_run, rs1_addr, we, rd_addr, rd_data, regs[rs1_addr]);
        rs2_data = read_port(in_run, rs2_addr, we, rd_addr, rd_data, regs[rs2_addr]);
    end

endmodule

// File: tb/tb_reg_file_clr.sv
// Directed bench for reg_file_clr: one bypassing and one non-bypassing instance
// share the same stimulus; expectations are hand-computed constants.
module tb_reg_file_clr;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned AW    = 5;
    localparam int          SWEEP = 31;

    logic            clk = 1'b0;
    logic            rst;
    logic            we;
    logic [AW-1:0]   rd_addr;
    logic [XLEN-1:0] rd_data;
    logic [AW-1:0]   rs1_addr;
    logic [AW-1:0]   rs2_addr;
    logic [XLEN-1:0] rs1_data,    rs2_data;
    logic [XLEN-1:0] rs1_data_nb, rs2_data_nb;
    logic            busy, busy_nb;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    reg_file_clr #(.XLEN(32), .NREGS(32), .AW(5), .BYPASS(1)) dut (
        .clk(clk), .rst(rst), .we(we), .rd_addr(rd_addr), .rd_data(rd_data),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .busy(busy)
    );

    reg_file_clr #(.XLEN(32), .NREGS(32), .AW(5), .BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .we(we), .rd_addr(rd_addr), .rd_data(rd_data),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data_nb), .rs2_data(rs2_data_nb), .busy(busy_nb)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Write one word in RUN: drive for one edge, then drop we.
    task automatic write_reg(input logic [AW-1:0] a, input logic [XLEN-1:0] v);
        we = 1'b1; rd_addr = a; rd_data = v;
        @(negedge clk);
        we = 1'b0;
    endtask

    // Count cycles with busy high from the current negedge; reads all addresses as it goes.
    // Stops early after stop_at cycles (0 = run to completion, bounded at 100).
    task automatic run_sweep(input int stop_at, input bit inject, output int n);
        n = 0;
        while (n < 100) begin
            rs1_addr = AW'(n);
            rs2_addr = AW'(31 - n);
            we = 1'b0;
            if (inject && n == 3) begin
                we = 1'b1; rd_addr = 5'd31; rd_data = 32'hFFFF_FFFF;
            end
            if (inject && n == 5) begin
                we = 1'b1; rd_addr = 5'd2; rd_data = 32'hFFFF_FFFF;
            end
            #1;
            if (!busy) break;
            if (rs1_data !== 32'h0 || rs2_data !== 32'h0 || rs1_data_nb !== 32'h0 || rs2_data_nb !== 32'h0) begin
                check("sweep_read_rs1", rs1_data, 32'h0);
                check("sweep_read_rs2", rs2_data, 32'h0);
                check("sweep_read_rs1_nb", rs1_data_nb, 32'h0);
                check("sweep_read_rs2_nb", rs2_data_nb, 32'h0);
            end
            n++;
            @(negedge clk);
            if (stop_at != 0 && n == stop_at) break;
        end
        we = 1'b0;
    endtask

    int n;

    initial begin
        rst = 1'b1; we = 1'b0; rd_addr = '0; rd_data = '0; rs1_addr = '0; rs2_addr = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_busy", 32'(busy), 32'h1);
        check("reset_busy_nb", 32'(busy_nb), 32'h1);
        check("reset_rs1", rs1_data, 32'h0);
        check("reset_rs2", rs2_data, 32'h0);

        // Sweep with writes attempted at sweep cycles 3 (x31) and 5 (x2).
        run_sweep(0, 1'b1, n);
        check("sweep_len", 32'(n), 32'(SWEEP));
        check("busy_fell_nb", 32'(busy_nb), 32'h0);
        rs1_addr = 5'd31; rs2_addr = 5'd2;
        #1;
        check("sweep_we_ignored_x31", rs1_data, 32'h0);
        check("sweep_we_ignored_x2", rs2_data, 32'h0);
        check("sweep_we_ignored_x2_nb", rs2_data_nb, 32'h0);
        @(negedge clk);

        // Basic write/read.
        write_reg(5'd5, 32'hDEAD_BEEF);
        rs1_addr = 5'd5; rs2_addr = 5'd5;
        #1;
        check("x5_rs1", rs1_data, 32'hDEAD_BEEF);
        check("x5_rs2", rs2_data, 32'hDEAD_BEEF);
        check("x5_rs1_nb", rs1_data_nb, 32'hDEAD_BEEF);
        @(negedge clk);

        // Distinct addresses on the two ports; top register as a boundary.
        write_reg(5'd31, 32'hCAFE_F00D);
        write_reg(5'd1, 32'h0000_0001);
        rs1_addr = 5'd31; rs2_addr = 5'd1;
        #1;
        check("x31_rs1", rs1_data, 32'hCAFE_F00D);
        check("x1_rs2", rs2_data, 32'h0000_0001);
        rs1_addr = 5'd1; rs2_addr = 5'd5;
        #1;
        check("x1_rs1", rs1_data, 32'h0000_0001);
        check("x5_rs2_again", rs2_data, 32'hDEAD_BEEF);
        @(negedge clk);

        // x0 is hardwired, including against bypass.
        we = 1'b1; rd_addr = 5'd0; rd_data = 32'h1234_5678; rs1_addr = 5'd0;
        #1;
        check("x0_same_cycle", rs1_data, 32'h0);
        check("x0_same_cycle_nb", rs1_data_nb, 32'h0);
        @(negedge clk);
        we = 1'b0;
        #1;
        check("x0_later", rs1_data, 32'h0);
        check("x0_later_nb", rs1_data_nb, 32'h0);
        @(negedge clk);

        // Bypass vs. stored-only read.
        write_reg(5'd7, 32'h1111_1111);
        we = 1'b1; rd_addr = 5'd7; rd_data = 32'h2222_2222; rs2_addr = 5'd7; rs1_addr = 5'd5;
        #1;
        check("bypass_rs2", rs2_data, 32'h2222_2222);
        check("nobypass_rs2", rs2_data_nb, 32'h1111_1111);
        check("bypass_other_port", rs1_data, 32'hDEAD_BEEF);
        @(negedge clk);
        we = 1'b0;
        #1;
        check("bypass_next", rs2_data, 32'h2222_2222);
        check("nobypass_next", rs2_data_nb, 32'h2222_2222);
        @(negedge clk);

        // Mid-sweep reset plus rst/we collision.
        write_reg(5'd9, 32'hA5A5_A5A5);
        rs1_addr = 5'd9;
        #1;
        check("x9_written", rs1_data, 32'hA5A5_A5A5);
        @(negedge clk);
        rst = 1'b1; we = 1'b1; rd_addr = 5'd9; rd_data = 32'h5A5A_5A5A;
        @(negedge clk);
        rst = 1'b0; we = 1'b0;
        #1;
        check("collide_busy", 32'(busy), 32'h1);
        run_sweep(10, 1'b0, n);
        check("partial_sweep_len", 32'(n), 32'd10);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        run_sweep(0, 1'b0, n);
        check("resweep_len", 32'(n), 32'(SWEEP));
        rs1_addr = 5'd9; rs2_addr = 5'd5;
        #1;
        check("x9_cleared", rs1_data, 32'h0);
        check("x9_cleared_nb", rs1_data_nb, 32'h0);
        check("x5_cleared", rs2_data, 32'h0);
        check("busy_low_end", 32'(busy), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/reg_file_clr.md
Name: reg_file_clr

Overview:
- Integer register file for the single-cycle core: 2 asynchronous read ports and 1 synchronous write port.
- Sits downstream of the per-bit load-enable register storage. Each architectural register is an XLEN-wide word with a per-word load select, and the decoded write enable drives that select.
- After reset, a sequencer sweeps every register to zero, one register per cycle, so the storage can later map onto RAM without a global clear.
- Feeds the ALU operand muxes. Accepts write-back data from the result mux.

Parameters:
- XLEN, 32, data width in bits.
- NREGS, 32, number of registers. Must be a power of 2 and at least 4.
- AW, 5, address width. Must equal log2(NREGS).
- BYPASS, 1. When 1, a same-cycle write is forwarded to the read ports. When 0, reads return the stored value only.

Ports:
- clk  in  1  Rising-edge clock.
- rst  in  1  Reset: synchronous, active-high. The clock port is named clk and the reset port is named rst, as elsewhere in the codebase.
- we  in  1  Write enable.
- rd_addr  in  AW  Write address.
- rd_data  in  XLEN  Write data.
- rs1_addr  in  AW  Read port 1 address.
- rs2_addr  in  AW  Read port 2 address.
- rs1_data  out  XLEN  Read port 1 data (combinational).
- rs2_data  out  XLEN  Read port 2 data (combinational).
- busy  out  1  High while the clear sweep is in progress. The core must stall fetch while busy=1.

Behaviour:
- States: CLEAR, RUN. Internal sweep counter cnt is AW bits wide.
- Reset:
  - rst=1 sampled at a rising edge gives state<=CLEAR and cnt<=1.
  - No register is written on that edge.
  - rst has priority over everything, including we.
- CLEAR state:
  - Each edge with rst=0: reg[cnt]<=0 and cnt<=cnt+1.
  - If cnt==NREGS-1 at that edge, state<=RUN (this is the final write, to reg[NREGS-1]).
  - Sweep length is therefore NREGS-1 edges after rst deasserts (31 at the defaults).
  - Register 0 is never stored; it is hardwired.
- busy output:
  - busy = (state==CLEAR). It is registered, driven purely from state.
  - busy=1 from the edge after rst is sampled high until the sweep's final edge.
- During CLEAR:
  - we is ignored.
  - rs1_data and rs2_data read 0 regardless of address.
- RUN state, write path:
  - At a rising edge with we=1 and rd_addr!=0: reg[rd_addr]<=rd_data.
  - Writes to address 0 are discarded.
- RUN state, read path:
  - rsN_data = 0 if rsN_addr==0.
  - Otherwise, if BYPASS=1 and we=1 and rd_addr==rsN_addr, rsN_data = rd_data.
  - Otherwise rsN_data = reg[rsN_addr].
- Both read ports may address the same register or the write register in the same cycle without conflict.
- Reset asserted mid-sweep or mid-RUN restarts the sweep at cnt=1. Partially cleared contents are simply re-cleared.
- Output values after the reset edge: busy=1, rs1_data=0, rs2_data=0. No X may reach any output after the first reset edge.
- No arithmetic beyond the cnt increment. cnt must not wrap, because the sweep exits at NREGS-1.

Decomposition:
- Shared package rf_pkg holds:
  - XLEN default;
  - state enum {CLEAR, RUN};
  - the register-0 address constant.
- One natural sub-module: word_reg, an XLEN-wide register with load select.
  - Load select = (state==RUN & we & rd_addr==i) | (state==CLEAR & cnt==i).
  - Load data = rd_data when in RUN, else 0.
  - Instantiated NREGS-1 times.
- Read muxes and the sweep FSM live in the top level.

Test Plan:
- Reset sweep: rst=1 for 1 cycle, then 0 → busy=1 for exactly 31 cycles then 0. Reads of every address during the sweep return 0x00000000.
- Basic write/read: after the sweep, write 0xDEADBEEF to x5. Next cycle rs1_addr=5, rs2_addr=5 → both read 0xDEADBEEF.
- x0 hardwired: write 0x12345678 to x0 → rs1_addr=0 reads 0x00000000 in the same and all later cycles.
- Bypass: BYPASS=1, x7 holds 0x11111111. In one cycle we=1, rd_addr=7, rd_data=0x22222222, rs2_addr=7 → rs2_data=0x22222222 that cycle. With BYPASS=0 the same stimulus gives 0x11111111 that cycle and 0x22222222 the next.
- Write ignored during sweep: we=1, rd_addr=31, rd_data=0xFFFFFFFF at sweep cycle 3 → x31 reads 0 after busy falls.
- Mid-sweep reset plus rst/we collision: write 0xA5A5A5A5 to x9 in RUN. Assert rst with we=1 (rd_addr=9, rd_data=0x5A5A5A5A), release rst, then pulse rst again at sweep cycle 10 → busy stays high for 31 cycles after the second release, and x9 reads 0.
